// File: rtl/led_ctrl_pkg.sv
// Shared definitions for the LED frame controller, the serializer and their benches:
// FSM state encoding and port width helpers.
package led_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COPY  = 2'd1,
    ST_START = 2'd2,
    ST_WAIT  = 2'd3
  } led_state_e;

  // Address width: max(1, clog2(led_cnt)) so a single-LED chain still has a port bit.
  function automatic int calc_aw(input int led_cnt);
    return (led_cnt > 2) ? $clog2(led_cnt) : 1;
  endfunction

  // Pixel width: all colour channels of one LED packed together.
  function automatic int calc_pw(input int channels, input int bits_per_channel);
    return channels * bits_per_channel;
  endfunction

endpackage

// File: rtl/led_frame_timer.sv
// Free-running frame period counter; emits a registered one-cycle tick every PERIOD cycles.
// Restarts from 0 on reset.
module led_frame_timer #(
  parameter int PERIOD = 500000
) (
  input  logic clk,
  input  logic reset,
  output logic o_tick
);

  localparam int TW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [TW-1:0] LAST = TW'(PERIOD - 1);

  logic [TW-1:0] r_cnt;
  logic          r_tick;

  // Count 0..PERIOD-1 and pulse the tick on wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (r_cnt == LAST) begin
      r_cnt  <= '0;
      r_tick <= 1'b1;
    end else begin
      r_cnt  <= r_cnt + TW'(1);
      r_tick <= 1'b0;
    end
  end

  assign o_tick = r_tick;

endmodule

// File: rtl/led_frame_ctrl.sv
// Double-buffered frame controller in front of the serial LED driver.
// Writes land in the back buffer; a commit copies back->front and launches one frame.
// The front buffer is frozen while a frame is on the wire.
// Optional: define LED_FRAME_CTRL_AUTO_REFRESH_EN to add a periodic internal commit.
module led_frame_ctrl
  import led_ctrl_pkg::*;
#(
  parameter  int LED_CNT       = 3,
  parameter  int CHANNELS      = 3,
  parameter  int BITPERCHANNEL = 8,
  parameter  int WAIT_TIMEOUT  = 100000,
  parameter  int FRAME_PERIOD  = 500000,
  localparam int AW            = calc_aw(LED_CNT),
  localparam int PW            = calc_pw(CHANNELS, BITPERCHANNEL)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_wr_valid,
  output logic                  o_wr_ready,
  input  logic [AW-1:0]         i_wr_addr,
  input  logic [PW-1:0]         i_wr_data,
  input  logic                  i_commit,
  output logic [LED_CNT*PW-1:0] o_frame_data,
  output logic                  o_frame_start,
  input  logic                  i_frame_done,
  output logic                  o_busy,
  output logic                  o_wr_err,
  output logic                  o_timeout
);

  localparam int CW = (WAIT_TIMEOUT > 0) ? $clog2(WAIT_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(WAIT_TIMEOUT - 1);
  localparam logic [AW:0]   LED_LIMIT = (AW + 1)'(LED_CNT);

  led_state_e                  r_state;
  logic                        r_pending;
  logic                        r_frame_start;
  logic                        r_timeout;
  logic                        r_wr_err;
  logic [CW-1:0]               r_cnt;
  logic [LED_CNT-1:0][PW-1:0]  r_back;
  logic [LED_CNT-1:0][PW-1:0]  r_front;
  logic                        w_commit;
  logic                        w_wr_fire;

`ifdef LED_FRAME_CTRL_AUTO_REFRESH_EN
  logic w_tick;

  led_frame_timer #(
    .PERIOD(FRAME_PERIOD)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .o_tick(w_tick)
  );

  assign w_commit = i_commit | w_tick;
`else
  logic w_unused_period;
  assign w_unused_period = ^FRAME_PERIOD;
  assign w_commit        = i_commit;
`endif

  assign w_wr_fire = i_wr_valid & o_wr_ready;

  // Pixel writes into the back buffer; out-of-range addresses are swallowed and flagged.
  // NOTE: the back buffer is reset because it must read all-zero after reset; a plain
  // storage array without that visible requirement would be left unreset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_back   <= '0;
      r_wr_err <= 1'b0;
    end else if (w_wr_fire) begin
      if ({1'b0, i_wr_addr} < LED_LIMIT) begin
        r_back[i_wr_addr] <= i_wr_data;
      end else begin
        r_wr_err <= 1'b1;
      end
    end
  end

  // Frame FSM: copy, launch, wait for completion or timeout; coalesces commits into pending.
  // NOTE: non-blocking assignments throughout so every register sees pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_pending     <= 1'b0;
      r_frame_start <= 1'b0;
      r_timeout     <= 1'b0;
      r_cnt         <= '0;
      r_front       <= '0;
    end else begin
      r_frame_start <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (r_pending || w_commit) begin
            r_state <= ST_COPY;
          end
        end
        ST_COPY: begin
          r_front       <= r_back;
          r_frame_start <= 1'b1;
          r_state       <= ST_START;
        end
        ST_START: begin
          r_cnt   <= '0;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (i_frame_done) begin
            r_state <= ST_IDLE;
          end else if ((WAIT_TIMEOUT != 0) && (r_cnt == CNT_LAST)) begin
            r_state   <= ST_IDLE;
            r_timeout <= 1'b1;
          end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      // Pending is consumed on the IDLE->COPY step; any other commit just arms it.
      if ((r_state == ST_IDLE) && (r_pending || w_commit)) begin
        r_pending <= 1'b0;
      end else if (w_commit) begin
        r_pending <= 1'b1;
      end
    end
  end

  assign o_wr_ready    = (r_state != ST_COPY);
  assign o_busy        = (r_state != ST_IDLE);
  assign o_frame_start = r_frame_start;
  assign o_frame_data  = r_front;
  assign o_wr_err      = r_wr_err;
  assign o_timeout     = r_timeout;

endmodule

// File: tb/tb_led_frame_ctrl.sv
// Directed bench for led_frame_ctrl (LED_CNT=3, 24-bit pixels, WAIT_TIMEOUT=16, FRAME_PERIOD=50).
module tb_led_frame_ctrl;

  localparam int LED_CNT = 3;
  localparam int AW      = 2;
  localparam int PW      = 24;
  localparam int FW      = LED_CNT * PW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          i_wr_valid = 1'b0;
  logic          o_wr_ready;
  logic [AW-1:0] i_wr_addr = '0;
  logic [PW-1:0] i_wr_data = '0;
  logic          i_commit = 1'b0;
  logic [FW-1:0] o_frame_data;
  logic          o_frame_start;
  logic          i_frame_done = 1'b0;
  logic          o_busy;
  logic          o_wr_err;
  logic          o_timeout;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [FW-1:0] FRAME_A = 72'h0000FF_000000_FF0000;
  localparam logic [FW-1:0] FRAME_B = 72'h0000FF_00FF00_FF0000;

  led_frame_ctrl #(
    .LED_CNT      (LED_CNT),
    .CHANNELS     (3),
    .BITPERCHANNEL(8),
    .WAIT_TIMEOUT (16),
    .FRAME_PERIOD (50)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .i_wr_valid   (i_wr_valid),
    .o_wr_ready   (o_wr_ready),
    .i_wr_addr    (i_wr_addr),
    .i_wr_data    (i_wr_data),
    .i_commit     (i_commit),
    .o_frame_data (o_frame_data),
    .o_frame_start(o_frame_start),
    .i_frame_done (i_frame_done),
    .o_busy       (o_busy),
    .o_wr_err     (o_wr_err),
    .o_timeout    (o_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_pixel(input logic [AW-1:0] addr, input logic [PW-1:0] data);
    i_wr_valid = 1'b1;
    i_wr_addr  = addr;
    i_wr_data  = data;
    tick();
    i_wr_valid = 1'b0;
  endtask

  task automatic pulse_commit();
    i_commit = 1'b1;
    tick();
    i_commit = 1'b0;
  endtask

  task automatic pulse_done();
    i_frame_done = 1'b1;
    tick();
    i_frame_done = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    n_checks++;
    if (o_wr_ready !== 1'b1) begin n_errors++; $display("FAIL reset_wr_ready got %b exp 1", o_wr_ready); end
    n_checks++;
    if (o_frame_data !== '0) begin n_errors++; $display("FAIL reset_frame_data got %h exp 0", o_frame_data); end
    n_checks++;
    if ({o_frame_start, o_busy, o_wr_err, o_timeout} !== 4'b0000) begin
      n_errors++;
      $display("FAIL reset_flags got %b exp 0000", {o_frame_start, o_busy, o_wr_err, o_timeout});
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_commit_latency();
    write_pixel(2'd0, 24'hFF0000);
    write_pixel(2'd2, 24'h0000FF);
    pulse_commit();
    n_checks++;
    if ({o_busy, o_wr_ready, o_frame_start} !== 3'b100) begin
      n_errors++;
      $display("FAIL copy_cycle busy/ready/start got %b exp 100", {o_busy, o_wr_ready, o_frame_start});
    end
    tick();
    n_checks++;
    if (o_frame_start !== 1'b1) begin n_errors++; $display("FAIL latency_start got %b exp 1", o_frame_start); end
    n_checks++;
    if (o_frame_data !== FRAME_A) begin n_errors++; $display("FAIL first_frame got %h exp %h", o_frame_data, FRAME_A); end
    tick();
    n_checks++;
    if ({o_frame_start, o_busy} !== 2'b01) begin
      n_errors++;
      $display("FAIL start_one_cycle start/busy got %b exp 01", {o_frame_start, o_busy});
    end
  endtask

  task automatic test_write_during_wait();
    write_pixel(2'd1, 24'h00FF00);
    n_checks++;
    if (o_frame_data !== FRAME_A) begin n_errors++; $display("FAIL wait_frozen got %h exp %h", o_frame_data, FRAME_A); end
    repeat (3) tick();
    pulse_done();
    n_checks++;
    if ({o_busy, o_frame_data} !== {1'b0, FRAME_A}) begin
      n_errors++;
      $display("FAIL after_done busy=%b data=%h exp busy=0 data=%h", o_busy, o_frame_data, FRAME_A);
    end
    pulse_commit();
    tick();
    n_checks++;
    if ({o_frame_start, o_frame_data} !== {1'b1, FRAME_B}) begin
      n_errors++;
      $display("FAIL second_frame start=%b data=%h exp start=1 data=%h", o_frame_start, o_frame_data, FRAME_B);
    end
    tick();
    pulse_done();
  endtask

  task automatic test_coalesce();
    int starts;
    pulse_commit();
    tick();
    tick();
    repeat (3) begin
      pulse_commit();
      tick();
    end
    pulse_done();
    n_checks++;
    if (o_busy !== 1'b0) begin n_errors++; $display("FAIL coalesce_idle busy got %b exp 0", o_busy); end
    tick();
    tick();
    n_checks++;
    if (o_frame_start !== 1'b1) begin n_errors++; $display("FAIL coalesce_extra_start got %b exp 1", o_frame_start); end
    tick();
    pulse_done();
    starts = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (o_frame_start === 1'b1) starts++;
    end
    n_checks++;
    if (starts !== 0 || o_busy !== 1'b0) begin
      n_errors++;
      $display("FAIL coalesce_no_third starts=%0d busy=%b exp starts=0 busy=0", starts, o_busy);
    end
  endtask

  task automatic test_wr_err();
    n_checks++;
    if (o_wr_ready !== 1'b1) begin n_errors++; $display("FAIL bad_addr_ready got %b exp 1", o_wr_ready); end
    write_pixel(2'd3, 24'h123456);
    n_checks++;
    if (o_wr_err !== 1'b1) begin n_errors++; $display("FAIL wr_err_set got %b exp 1", o_wr_err); end
    pulse_commit();
    tick();
    n_checks++;
    if (o_frame_data !== FRAME_B) begin n_errors++; $display("FAIL bad_addr_dropped got %h exp %h", o_frame_data, FRAME_B); end
    tick();
    pulse_done();
    repeat (3) tick();
    n_checks++;
    if (o_wr_err !== 1'b1) begin n_errors++; $display("FAIL wr_err_sticky got %b exp 1", o_wr_err); end
  endtask

  task automatic test_done_outside_wait();
    pulse_done();
    n_checks++;
    if ({o_busy, o_frame_start} !== 2'b00) begin
      n_errors++;
      $display("FAIL stray_done busy/start got %b exp 00", {o_busy, o_frame_start});
    end
  endtask

  task automatic test_timeout();
    pulse_commit();
    tick();
    tick();
    repeat (15) tick();
    n_checks++;
    if ({o_busy, o_timeout} !== 2'b10) begin
      n_errors++;
      $display("FAIL timeout_early busy/timeout got %b exp 10", {o_busy, o_timeout});
    end
    tick();
    n_checks++;
    if ({o_busy, o_timeout} !== 2'b01) begin
      n_errors++;
      $display("FAIL timeout_abort busy/timeout got %b exp 01", {o_busy, o_timeout});
    end
    repeat (2) tick();
    n_checks++;
    if (o_timeout !== 1'b1) begin n_errors++; $display("FAIL timeout_sticky got %b exp 1", o_timeout); end
  endtask

  task automatic test_reset_mid_frame();
    pulse_commit();
    tick();
    tick();
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({o_busy, o_frame_start, o_wr_err, o_timeout, o_wr_ready} !== 5'b00001) begin
      n_errors++;
      $display("FAIL async_reset_flags got %b exp 00001", {o_busy, o_frame_start, o_wr_err, o_timeout, o_wr_ready});
    end
    n_checks++;
    if (o_frame_data !== '0) begin n_errors++; $display("FAIL async_reset_data got %h exp 0", o_frame_data); end
    @(negedge clk);
    reset = 1'b0;
    tick();
    tick();
    n_checks++;
    if (o_busy !== 1'b0) begin n_errors++; $display("FAIL post_reset_idle busy got %b exp 0", o_busy); end
    pulse_commit();
    tick();
    n_checks++;
    if ({o_frame_start, o_frame_data} !== {1'b1, {FW{1'b0}}}) begin
      n_errors++;
      $display("FAIL post_reset_frame start=%b data=%h exp start=1 data=0", o_frame_start, o_frame_data);
    end
    tick();
    pulse_done();
  endtask

`ifdef LED_FRAME_CTRL_AUTO_REFRESH_EN
  task automatic test_auto_refresh();
    int starts;
    int last_t;
    int bad_gap;
    starts  = 0;
    last_t  = -1;
    bad_gap = 0;
    i_frame_done = 1'b1;
    for (int t = 0; t < 170; t++) begin
      tick();
      if (o_frame_start === 1'b1) begin
        if (last_t >= 0 && (t - last_t) != 50) bad_gap++;
        last_t = t;
        starts++;
      end
    end
    i_frame_done = 1'b0;
    n_checks++;
    if (starts !== 3) begin n_errors++; $display("FAIL auto_start_count got %0d exp 3", starts); end
    n_checks++;
    if (bad_gap !== 0) begin n_errors++; $display("FAIL auto_period bad_gaps got %0d exp 0", bad_gap); end
  endtask
`endif

  initial begin
    test_reset();
`ifdef LED_FRAME_CTRL_AUTO_REFRESH_EN
    test_auto_refresh();
`else
    test_commit_latency();
    test_write_during_wait();
    test_coalesce();
    test_wr_err();
    test_done_outside_wait();
    test_timeout();
    test_reset_mid_frame();
`endif
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
